// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder with a circular-buffer output FIFO.
// Unencodable requests are still queued, as a NOP flagged with err.
module rv_instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_class,
    input  logic [2:0]               in_funct3,
    input  logic                     in_funct7b5,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [31:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               err_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        CLS_RALU   = 3'd0,
        CLS_IALU   = 3'd1,
        CLS_LW     = 3'd2,
        CLS_SW     = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5
    } instr_class_t;

    instr_class_t       cls;
    logic               is_shift;
    logic               fits12;
    logic               fits13;
    logic               fits21;
    logic [31:0]        enc_word;
    logic               enc_ok;
    logic [31:0]        push_word;
    logic               push;
    logic               pop;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        mem_instr [DEPTH];
    logic               mem_err   [DEPTH];

    always_comb begin
        cls      = instr_class_t'(in_class);
        is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
        fits12   = (&in_imm[31:11]) || (~|in_imm[31:11]);
        fits13   = (&in_imm[31:12]) || (~|in_imm[31:12]);
        fits21   = (&in_imm[31:20]) || (~|in_imm[31:20]);
        enc_word = '0;
        enc_ok   = 1'b0;
        case (cls)
            CLS_RALU: begin
                enc_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
                enc_ok   = 1'b1;
            end
            CLS_IALU: begin
                if (is_shift) begin
                    enc_word = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                    enc_ok   = (in_imm[31:5] == '0) && !(in_funct7b5 && (in_funct3 == 3'b001));
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                    enc_ok   = fits12;
                end
            end
            CLS_LW: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                enc_ok   = fits12;
            end
            CLS_SW: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
                enc_ok   = fits12;
            end
            CLS_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                enc_ok   = fits13 && !in_imm[0] && (in_funct3[2:1] != 2'b01);
            end
            CLS_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                enc_ok   = fits21 && !in_imm[0];
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
        push_word = enc_ok ? enc_word : 32'h0000_0013;
    end

    // Handshakes depend only on the registered level; no bypass when full.
    assign in_ready  = (level != LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Gate the head with out_valid so the outputs read zero while empty.
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_err   = out_valid ? mem_err[rd_ptr]   : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= push_word;
            mem_err[wr_ptr]   <= !enc_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push && !enc_ok && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Randomized self-checking bench for rv_instr_encoder against a queue-based
// reference model that encodes from integer ranges and field layouts.
module tb_rv_instr_encoder;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [2:0]  level;
    logic [7:0]  err_cnt;

    rv_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_class    (in_class),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_err     (out_err),
        .level       (level),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [32:0] mq[$];
    logic [7:0]  m_err_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_enc(input logic [2:0] cls, input logic [2:0] f3,
                                             input logic b5, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input int imm);
        logic [31:0] u = imm;
        logic [31:0] w = '0;
        bit ok = 0;
        case (cls)
            3'd0: begin ok = 1; w = {1'b0, b5, 5'b0, rs2, rs1, f3, rd, 7'h33}; end
            3'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (imm >= 0) && (imm <= 31) && !(f3 == 3'd1 && b5);
                    w  = {1'b0, b5, 5'b0, u[4:0], rs1, f3, rd, 7'h13};
                end else begin
                    ok = (imm >= -2048) && (imm <= 2047);
                    w  = {u[11:0], rs1, f3, rd, 7'h13};
                end
            end
            3'd2: begin ok = (imm >= -2048) && (imm <= 2047); w = {u[11:0], rs1, 3'b010, rd, 7'h03}; end
            3'd3: begin ok = (imm >= -2048) && (imm <= 2047); w = {u[11:5], rs2, rs1, 3'b010, u[4:0], 7'h23}; end
            3'd4: begin
                ok = (f3 != 3'd2) && (f3 != 3'd3) && (imm >= -4096) && (imm <= 4095) && ((imm & 1) == 0);
                w  = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], 7'h63};
            end
            3'd5: begin
                ok = (imm >= -1048576) && (imm <= 1048575) && ((imm & 1) == 0);
                w  = {u[20], u[10:1], u[11], u[19:12], rd, 7'h6F};
            end
            default: ok = 0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    // Compare against the model, then advance one clock and update the model.
    task automatic step();
        bit push;
        bit pop;
        logic [32:0] ent;
        int sz = mq.size();
        check("in_ready", {31'b0, in_ready}, {31'b0, sz != DEPTH});
        check("out_valid", {31'b0, out_valid}, {31'b0, sz != 0});
        check("level", {29'b0, level}, sz);
        check("err_cnt", {24'b0, err_cnt}, {24'b0, m_err_cnt});
        if (sz != 0) begin
            check("out_instr", out_instr, mq[0][31:0]);
            check("out_err", {31'b0, out_err}, {31'b0, mq[0][32]});
        end
        push = in_valid && (sz != DEPTH);
        pop  = (sz != 0) && out_ready;
        ent  = ref_enc(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, int'(signed'(in_imm)));
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(ent);
            if (ent[32] && m_err_cnt != 8'd255) m_err_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] cls, input logic [2:0] f3, input logic b5,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input int imm);
        in_valid    = 1'b1;
        in_class    = cls;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
    endtask

    function automatic int rand_imm();
        int bnd[13] = '{-2049, -2048, 2047, 2048, -4096, 4094, 4095, 4096, 32, -1,
                        1048574, -1048576, 1048576};
        case ($urandom_range(0, 5))
            0:       return int'($urandom_range(0, 31));
            1:       return int'($urandom_range(0, 4095)) - 2048;
            2:       return int'($urandom_range(0, 8191)) - 4096;
            3:       return bnd[$urandom_range(0, 12)];
            4:       return int'($urandom);
            default: return int'($urandom_range(0, 2097151)) - 1048576;
        endcase
    endfunction

    task automatic rand_req();
        set_req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        set_req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_err", {31'b0, out_err}, 32'h0);
        step();

        // SUB x3, x1, x2
        set_req(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 0);
        step();
        in_valid = 1'b0;
        check("sub_valid", {31'b0, out_valid}, 32'h1);
        check("sub_word", out_instr, 32'h4020_81B3);
        check("sub_err", {31'b0, out_err}, 32'h0);
        step();

        set_req(3'd3, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, -4);
        step();
        check("sw_word", out_instr, 32'hFE51_2E23);
        set_req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 8);
        step();
        check("beq_word", out_instr, 32'h0020_8463);

        set_req(3'd2, 3'd0, 1'b0, 5'd4, 5'd1, 5'd0, 2048);
        step();
        check("lw_ovf_word", out_instr, 32'h0000_0013);
        check("lw_ovf_err", {31'b0, out_err}, 32'h1);
        check("lw_ovf_cnt", {24'b0, err_cnt}, 32'd1);
        set_req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 3);
        step();
        check("jal_odd_cnt", {24'b0, err_cnt}, 32'd2);
        drain();

        // Fill to full with the consumer stalled, then release it.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_req();
            step();
        end
        rand_req();
        check("full_ready", {31'b0, in_ready}, 32'h0);
        check("full_level", {29'b0, level}, 32'd4);
        step();
        step();
        check("full_hold", {29'b0, level}, 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            rand_req();
        end
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_req();
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_req();
            step();
            check("steady_level", {29'b0, level}, 32'd2);
        end
        drain();

        // Asynchronous reset with three entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0);
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_level", {29'b0, level}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'h0);
        check("arst_level", {29'b0, level}, 32'd0);
        check("arst_errcnt", {24'b0, err_cnt}, 32'd0);
        mq.delete();
        m_err_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        set_req(3'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, -7);
        step();
        in_valid = 1'b0;
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);
        check("post_rst_word", out_instr, 32'hFF93_0293);
        step();

        for (int i = 0; i < 600; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) rand_req();
            else in_valid = 1'b0;
            step();
        end
        drain();

        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_req(3'($urandom_range(6, 7)), 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0);
            step();
        end
        check("errcnt_sat", {24'b0, err_cnt}, 32'd255);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
